// File: rtl/sparc_pkg.sv
// rtl/sparc_pkg.sv - shared trap types, sequencer states and window arithmetic (ST_ERROR exists only with TRAP_SEQ_ERROR_MODE_EN)
package sparc_pkg;

    localparam int DEFAULT_NWINDOWS = 8;

    localparam logic [7:0] TT_ILLEGAL_INSTR = 8'h02;
    localparam logic [7:0] TT_INT_BASE      = 8'h10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T_ET,
        ST_T_PS,
        ST_T_S,
        ST_T_WIN,
        ST_T_TBR,
        ST_R_WIN,
        ST_R_S,
        ST_R_ET,
`ifdef TRAP_SEQ_ERROR_MODE_EN
        ST_DONE,
        ST_ERROR
`else
        ST_DONE
`endif
    } seq_state_t;

    // Window decrement used on trap entry; wraps to the top window.
    function automatic logic [4:0] cwp_dec(input logic [4:0] cwp, input int nwin);
        return (cwp == 5'd0) ? 5'(nwin - 1) : cwp - 5'd1;
    endfunction

    // Window increment used on RETT; wraps to window 0.
    function automatic logic [4:0] cwp_inc(input logic [4:0] cwp, input int nwin);
        return (cwp == 5'(nwin - 1)) ? 5'd0 : cwp + 5'd1;
    endfunction

endpackage

// File: rtl/trap_irq_qual.sv
// rtl/trap_irq_qual.sv - combinational interrupt qualification and trap type
module trap_irq_qual
    import sparc_pkg::*;
(
    input  logic [3:0] irl,
    input  logic [3:0] pil,
    input  logic       et,
    output logic       pending,
    output logic [7:0] tt
);

    // Level 15 is non-maskable by PIL; any other level must exceed PIL.
    assign pending = et && (irl != 4'd0) && ((irl == 4'hf) || (irl > pil));
    assign tt      = TT_INT_BASE + {4'd0, irl};

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - serializes trap entry and RETT into single-field PSR writes (optional TRAP_SEQ_ERROR_MODE_EN)
module trap_sequencer
    import sparc_pkg::*;
#(
    parameter int NWINDOWS = DEFAULT_NWINDOWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_trap_req,
    input  logic [7:0] sync_tt,
    input  logic [3:0] irl,
    input  logic       rett_req,
    input  logic       psr_et,
    input  logic       psr_s,
    input  logic       psr_ps,
    input  logic [3:0] psr_pil,
    input  logic [4:0] psr_cwp,
    output logic       req_ack,
    output logic       ET_set,
    output logic       ET_in,
    output logic       PS_set,
    output logic       PS_in,
    output logic       S_set,
    output logic       S_in,
    output logic       CWP_wr,
    output logic [4:0] CWP_in,
    output logic       tbr_tt_wr,
    output logic [7:0] tbr_tt,
    output logic       busy,
    output logic       trap_done,
    output logic       error_mode
);

    seq_state_t state, next_state;

    logic [7:0] tt_snap;
    logic       s_snap;
    logic       ps_snap;
    logic [4:0] cwp_snap;

    logic       snap_load;
    logic [7:0] snap_tt;

    logic       irq_pending;
    logic [7:0] irq_tt;

    trap_irq_qual u_irq_qual (
        .irl     (irl),
        .pil     (psr_pil),
        .et      (psr_et),
        .pending (irq_pending),
        .tt      (irq_tt)
    );

    // State register and request snapshot; reset abandons any partial sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tt_snap  <= 8'h00;
            s_snap   <= 1'b0;
            ps_snap  <= 1'b0;
            cwp_snap <= 5'd0;
        end else begin
            state <= next_state;
            if (snap_load) begin
                tt_snap  <= snap_tt;
                s_snap   <= psr_s;
                ps_snap  <= psr_ps;
                cwp_snap <= psr_cwp;
            end
        end
    end

    // IDLE arbitration (sync trap > interrupt > RETT) and fixed step sequencing.
    always_comb begin
        next_state = state;
        req_ack    = 1'b0;
        snap_load  = 1'b0;
        snap_tt    = 8'h00;
        unique case (state)
            ST_IDLE: begin
                // Acking under reset would lose the request since the state cannot advance.
                if (!rst) begin
                    if (sync_trap_req) begin
                        req_ack   = 1'b1;
                        snap_load = 1'b1;
                        snap_tt   = sync_tt;
`ifdef TRAP_SEQ_ERROR_MODE_EN
                        next_state = psr_et ? ST_T_ET : ST_ERROR;
`else
                        next_state = ST_T_ET;
`endif
                    end else if (irq_pending) begin
                        req_ack    = 1'b1;
                        snap_load  = 1'b1;
                        snap_tt    = irq_tt;
                        next_state = ST_T_ET;
                    end else if (rett_req) begin
                        req_ack   = 1'b1;
                        snap_load = 1'b1;
                        // RETT with traps enabled is an illegal instruction trap.
                        if (psr_et) begin
                            snap_tt    = TT_ILLEGAL_INSTR;
                            next_state = ST_T_ET;
                        end else begin
                            next_state = ST_R_WIN;
                        end
                    end
                end
            end
            ST_T_ET:  next_state = ST_T_PS;
            ST_T_PS:  next_state = ST_T_S;
            ST_T_S:   next_state = ST_T_WIN;
            ST_T_WIN: next_state = ST_T_TBR;
            ST_T_TBR: next_state = ST_DONE;
            ST_R_WIN: next_state = ST_R_S;
            ST_R_S:   next_state = ST_R_ET;
            ST_R_ET:  next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
`ifdef TRAP_SEQ_ERROR_MODE_EN
            ST_ERROR: next_state = ST_ERROR;
`endif
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state and snapshots only.
    always_comb begin
        ET_set    = 1'b0;
        ET_in     = 1'b0;
        PS_set    = 1'b0;
        PS_in     = 1'b0;
        S_set     = 1'b0;
        S_in      = 1'b0;
        CWP_wr    = 1'b0;
        CWP_in    = 5'd0;
        tbr_tt_wr = 1'b0;
        tbr_tt    = 8'h00;
        trap_done = 1'b0;
        busy      = (state != ST_IDLE);
`ifdef TRAP_SEQ_ERROR_MODE_EN
        error_mode = (state == ST_ERROR);
`else
        error_mode = 1'b0;
`endif
        case (state)
            ST_T_ET: begin
                ET_set = 1'b1;
                ET_in  = 1'b0;
            end
            ST_T_PS: begin
                PS_set = 1'b1;
                PS_in  = s_snap;
            end
            ST_T_S: begin
                S_set = 1'b1;
                S_in  = 1'b1;
            end
            ST_T_WIN: begin
                CWP_wr = 1'b1;
                CWP_in = cwp_dec(cwp_snap, NWINDOWS);
            end
            ST_T_TBR: begin
                tbr_tt_wr = 1'b1;
                tbr_tt    = tt_snap;
            end
            ST_R_WIN: begin
                CWP_wr = 1'b1;
                CWP_in = cwp_inc(cwp_snap, NWINDOWS);
            end
            ST_R_S: begin
                S_set = 1'b1;
                S_in  = ps_snap;
            end
            ST_R_ET: begin
                ET_set = 1'b1;
                ET_in  = 1'b1;
            end
            ST_DONE: trap_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - table, hand-written and random checks of trap_sequencer
module tb_trap_sequencer;

    localparam int NW = 8;

    typedef logic [24:0] word_t;
    typedef word_t wq_t[$];

    localparam word_t W_ACK  = word_t'(1) << 24;
    localparam word_t W_ETS  = word_t'(1) << 23;
    localparam word_t W_ETI  = word_t'(1) << 22;
    localparam word_t W_PSS  = word_t'(1) << 21;
    localparam word_t W_PSI  = word_t'(1) << 20;
    localparam word_t W_SS   = word_t'(1) << 19;
    localparam word_t W_SI   = word_t'(1) << 18;
    localparam word_t W_CWR  = word_t'(1) << 17;
    localparam word_t W_TBW  = word_t'(1) << 11;
    localparam word_t W_BUSY = word_t'(1) << 2;
    localparam word_t W_DONE = word_t'(1) << 1;
    localparam word_t W_ERR  = word_t'(1);

    localparam int K_NONE = 0;
    localparam int K_TRAP = 1;
    localparam int K_RETT = 2;
    localparam int K_ERR  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync_trap_req;
    logic [7:0] sync_tt;
    logic [3:0] irl;
    logic       rett_req;
    logic       psr_et, psr_s, psr_ps;
    logic [3:0] psr_pil;
    logic [4:0] psr_cwp;
    logic       req_ack, ET_set, ET_in, PS_set, PS_in, S_set, S_in, CWP_wr;
    logic [4:0] CWP_in;
    logic       tbr_tt_wr;
    logic [7:0] tbr_tt;
    logic       busy, trap_done, error_mode;

    int n_tests = 0;
    int n_fail  = 0;

    trap_sequencer #(.NWINDOWS(NW)) dut (
        .clk           (clk),
        .rst           (rst),
        .sync_trap_req (sync_trap_req),
        .sync_tt       (sync_tt),
        .irl           (irl),
        .rett_req      (rett_req),
        .psr_et        (psr_et),
        .psr_s         (psr_s),
        .psr_ps        (psr_ps),
        .psr_pil       (psr_pil),
        .psr_cwp       (psr_cwp),
        .req_ack       (req_ack),
        .ET_set        (ET_set),
        .ET_in         (ET_in),
        .PS_set        (PS_set),
        .PS_in         (PS_in),
        .S_set         (S_set),
        .S_in          (S_in),
        .CWP_wr        (CWP_wr),
        .CWP_in        (CWP_in),
        .tbr_tt_wr     (tbr_tt_wr),
        .tbr_tt        (tbr_tt),
        .busy          (busy),
        .trap_done     (trap_done),
        .error_mode    (error_mode)
    );

    always #5 clk = ~clk;

    word_t act;
    assign act = {req_ack, ET_set, ET_in, PS_set, PS_in, S_set, S_in, CWP_wr, CWP_in,
                  tbr_tt_wr, tbr_tt, busy, trap_done, error_mode};

    // Expected per-cycle outputs from the accept cycle to the following idle cycle.
    function automatic wq_t build(input int kind, input logic [7:0] tt, input logic s,
                                  input logic ps, input logic [4:0] ncwp, input bit tail);
        wq_t q;
        word_t cw;
        word_t tw;
        cw = word_t'(ncwp) << 12;
        tw = word_t'(tt) << 3;
        if (kind == K_NONE) begin
            q.push_back('0);
            return q;
        end
        q.push_back(W_ACK);
        if (kind == K_TRAP) begin
            q.push_back(W_BUSY | W_ETS);
            q.push_back(W_BUSY | W_PSS | (s ? W_PSI : '0));
            q.push_back(W_BUSY | W_SS | W_SI);
            q.push_back(W_BUSY | W_CWR | cw);
            q.push_back(W_BUSY | W_TBW | tw);
            q.push_back(W_BUSY | W_DONE);
        end else if (kind == K_RETT) begin
            q.push_back(W_BUSY | W_CWR | cw);
            q.push_back(W_BUSY | W_SS | (ps ? W_SI : '0));
            q.push_back(W_BUSY | W_ETS | W_ETI);
            q.push_back(W_BUSY | W_DONE);
        end else begin
            for (int i = 0; i < 4; i++) q.push_back(W_BUSY | W_ERR);
        end
        if (tail && kind != K_ERR) q.push_back('0);
        return q;
    endfunction

    task automatic check(input string name, input int idx, input word_t e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, e);
        end
    endtask

    // Entered just after a rising edge; leaves just after a rising edge.
    task automatic run_trace(input string name, input wq_t exp, input int nwords,
                             input logic [2:0] clr, input bit scramble);
        for (int i = 0; i < nwords && i < exp.size(); i++) begin
            @(negedge clk);
            check(name, i, exp[i]);
            @(posedge clk);
            #1;
            if (i == 0) begin
                if (clr[2]) sync_trap_req = 1'b0;
                if (clr[1]) irl = 4'd0;
                if (clr[0]) rett_req = 1'b0;
                if (scramble) begin
                    psr_et  = 1'($urandom);
                    psr_s   = 1'($urandom);
                    psr_ps  = 1'($urandom);
                    psr_pil = 4'($urandom);
                    psr_cwp = 5'($urandom_range(0, NW - 1));
                end
            end
        end
    endtask

    typedef struct {
        string      name;
        logic       sync;
        logic [7:0] tt;
        logic [3:0] irl;
        logic       rett;
        logic       et, s, ps;
        logic [3:0] pil;
        logic [4:0] cwp;
        int         kind;
        logic [7:0] ett;
        logic [4:0] ecwp;
    } vec_t;

    vec_t vt[$];
    wq_t  tr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sync_trap_req = 1'b0; sync_tt = 8'h00; irl = 4'd0; rett_req = 1'b0;
        psr_et = 1'b0; psr_s = 1'b0; psr_ps = 1'b0; psr_pil = 4'd0; psr_cwp = 5'd0;

        //        name        sync tt     irl   rett et    s     ps    pil    cwp    kind    ett    ecwp
        vt.push_back('{"sync05",  1, 8'h05, 4'd0, 0,   1'b1, 1'b0, 1'b0, 4'd0,  5'd0, K_TRAP, 8'h05, 5'd7});
        vt.push_back('{"irl5pil5",0, 8'h00, 4'd5, 0,   1'b1, 1'b0, 1'b0, 4'd5,  5'd3, K_NONE, 8'h00, 5'd0});
        vt.push_back('{"irl6pil5",0, 8'h00, 4'd6, 0,   1'b1, 1'b1, 1'b0, 4'd5,  5'd4, K_TRAP, 8'h16, 5'd3});
        vt.push_back('{"irl15",   0, 8'h00, 4'd15,0,   1'b1, 1'b0, 1'b1, 4'd15, 5'd2, K_TRAP, 8'h1f, 5'd1});
        vt.push_back('{"irl_et0", 0, 8'h00, 4'd3, 0,   1'b0, 1'b0, 1'b0, 4'd0,  5'd2, K_NONE, 8'h00, 5'd0});
        vt.push_back('{"rett7",   0, 8'h00, 4'd0, 1,   1'b0, 1'b0, 1'b1, 4'd0,  5'd7, K_RETT, 8'h00, 5'd0});
        vt.push_back('{"rett3",   0, 8'h00, 4'd0, 1,   1'b0, 1'b1, 1'b0, 4'd0,  5'd3, K_RETT, 8'h00, 5'd4});
        vt.push_back('{"rett_et1",0, 8'h00, 4'd0, 1,   1'b1, 1'b1, 1'b1, 4'd0,  5'd5, K_TRAP, 8'h02, 5'd4});

        @(posedge clk); #1;
        @(negedge clk);
        check("reset", 0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 0, '0);
        @(posedge clk); #1;

        foreach (vt[k]) begin
            sync_trap_req = vt[k].sync; sync_tt = vt[k].tt; irl = vt[k].irl;
            rett_req = vt[k].rett; psr_et = vt[k].et; psr_s = vt[k].s; psr_ps = vt[k].ps;
            psr_pil = vt[k].pil; psr_cwp = vt[k].cwp;
            tr = build(vt[k].kind, vt[k].ett, vt[k].s, vt[k].ps, vt[k].ecwp, 1'b1);
            run_trace(vt[k].name, tr, tr.size(), 3'b111, 1'b1);
        end

        // All three requests at once: served strictly in priority order while others are held.
        sync_trap_req = 1'b1; sync_tt = 8'h33; irl = 4'd9; rett_req = 1'b1;
        psr_et = 1'b1; psr_s = 1'b1; psr_ps = 1'b0; psr_pil = 4'd0; psr_cwp = 5'd3;
        tr = build(K_TRAP, 8'h33, 1'b1, 1'b0, 5'd2, 1'b0);
        run_trace("prio_sync", tr, tr.size(), 3'b100, 1'b0);
        tr = build(K_TRAP, 8'h19, 1'b1, 1'b0, 5'd2, 1'b0);
        run_trace("prio_irq", tr, tr.size(), 3'b010, 1'b0);
        tr = build(K_TRAP, 8'h02, 1'b1, 1'b0, 5'd2, 1'b1);
        run_trace("prio_rett", tr, tr.size(), 3'b001, 1'b0);

        // Reset during T_S with the request still held, then re-acceptance.
        sync_trap_req = 1'b1; sync_tt = 8'h44; psr_et = 1'b1; psr_s = 1'b0; psr_cwp = 5'd1;
        tr = build(K_TRAP, 8'h44, 1'b0, 1'b0, 5'd0, 1'b1);
        run_trace("rst_mid", tr, 3, 3'b000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ts", 3, tr[3]);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_cleared", 0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_trace("rst_reaccept", tr, tr.size(), 3'b100, 1'b0);

        // Synchronous trap while traps are disabled.
        sync_trap_req = 1'b1; sync_tt = 8'h07; psr_et = 1'b0; psr_s = 1'b1; psr_cwp = 5'd6;
`ifdef TRAP_SEQ_ERROR_MODE_EN
        tr = build(K_ERR, 8'h07, 1'b1, 1'b0, 5'd5, 1'b1);
        run_trace("sync_et0_err", tr, tr.size(), 3'b000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sync_trap_req = 1'b0;
        @(negedge clk);
        check("err_exit_rst", 0, '0);
        @(posedge clk); #1;
`else
        tr = build(K_TRAP, 8'h07, 1'b1, 1'b0, 5'd5, 1'b1);
        run_trace("sync_et0", tr, tr.size(), 3'b100, 1'b0);
`endif

        // Random requests against the priority/field rules.
        for (int r = 0; r < 60; r++) begin
            int kind;
            int ncwp;
            logic [7:0] ett;
            sync_trap_req = ($urandom_range(0, 3) == 0);
            sync_tt  = 8'($urandom);
            irl      = 4'($urandom);
            rett_req = 1'($urandom);
            psr_et   = 1'($urandom);
            psr_s    = 1'($urandom);
            psr_ps   = 1'($urandom);
            psr_pil  = 4'($urandom);
            psr_cwp  = 5'($urandom_range(0, NW - 1));
`ifdef TRAP_SEQ_ERROR_MODE_EN
            if (sync_trap_req) psr_et = 1'b1;
`endif
            ett = 8'h00;
            if (sync_trap_req) begin
                kind = K_TRAP; ett = sync_tt;
            end else if (psr_et && irl != 0 && (int'(irl) == 15 || int'(irl) > int'(psr_pil))) begin
                kind = K_TRAP; ett = 8'(16 + int'(irl));
            end else if (rett_req) begin
                if (psr_et) begin
                    kind = K_TRAP; ett = 8'h02;
                end else begin
                    kind = K_RETT;
                end
            end else begin
                kind = K_NONE;
            end
            if (kind == K_RETT) ncwp = (int'(psr_cwp) + 1) % NW;
            else                ncwp = (int'(psr_cwp) + NW - 1) % NW;
            tr = build(kind, ett, psr_s, psr_ps, 5'(ncwp), 1'b1);
            run_trace($sformatf("rand%0d", r), tr, tr.size(), 3'b111, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
